// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, stack-pointer index and mem-stage states.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [4:0] SP_REG = 5'h1B;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM capture register for the packed execute-stage bundle; load enable, synchronous clear.
module ex_mem_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// Pipeline memory stage: captures the EX bundle, runs the dmem req/ready handshake, emits a WB pulse.
// Optional access abort after MEM_TIMEOUT wait cycles when MEM_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no access outstanding; accepts a new EX bundle
// ACCESS | dmem_req held with stable we/addr/wdata until ready (or timeout)
module mem_stage_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
`ifdef MEM_TIMEOUT_EN
  , parameter int MEM_TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic [REG_W-1:0]  DestReg_in,
  input  logic [DATA_W-1:0] EX_out_in,
  input  logic [DATA_W-1:0] MemWrite_data_in,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic [REG_W-1:0]  wb_DestReg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);
  import cpu_pkg::*;

  localparam int BW = 5 + REG_W + 2 * DATA_W;

  mem_state_t        state, state_n;
  logic [BW-1:0]     bun_d, bun_q;
  logic              q_reg_write, q_mem_write, q_mem_read, q_mem_to_reg, q_mem_src;
  logic [REG_W-1:0]  q_dest;
  logic [DATA_W-1:0] q_ex_out, q_wdata;
  logic              in_access, accept, is_mem_in, fin_nonmem, fin_mem;
  logic              timeout_hit, use_rdata;

  assign bun_d = {RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in,
                  DestReg_in, EX_out_in, MemWrite_data_in};
  assign {q_reg_write, q_mem_write, q_mem_read, q_mem_to_reg, q_mem_src,
          q_dest, q_ex_out, q_wdata} = bun_q;

  assign in_access  = (state == ACCESS);
  assign accept     = ex_valid && (state == IDLE);
  assign is_mem_in  = MemRead_in || MemWrite_in;
  assign fin_nonmem = accept && !is_mem_in;
  assign fin_mem    = in_access && (dmem_ready || timeout_hit);
  // Read-and-write together behaves as a store, so it never returns memory data.
  assign use_rdata  = q_mem_to_reg && q_mem_read && !q_mem_write;

  ex_mem_reg #(.W(BW)) u_ex_mem_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (bun_d),
    .q    (bun_q)
  );

  assign mem_stall  = in_access;
  assign dmem_req   = in_access;
  assign dmem_we    = in_access && q_mem_write;
  assign dmem_addr  = q_mem_src ? (q_ex_out - DATA_W'(1)) : q_ex_out;
  assign dmem_wdata = q_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1) + 1;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || !in_access) begin
      to_cnt <= '0;
    end else if (!dmem_ready) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Abort on the edge where the count would reach MEM_TIMEOUT; ready in that cycle wins.
  assign timeout_hit = in_access && !dmem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && is_mem_in) state_n = ACCESS;
      ACCESS:  if (fin_mem)             state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Non-memory ops complete on the accept edge straight from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_DestReg  <= '0;
      wb_data     <= '0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (fin_nonmem) begin
        wb_valid    <= 1'b1;
        wb_RegWrite <= RegWrite_in;
        wb_DestReg  <= DestReg_in;
        wb_data     <= EX_out_in;
      end else if (fin_mem) begin
        wb_valid    <= 1'b1;
        wb_RegWrite <= q_reg_write && !timeout_hit;
        wb_DestReg  <= q_dest;
        wb_data     <= (use_rdata && dmem_ready) ? dmem_rdata : q_ex_out;
        mem_err     <= timeout_hit;
      end
    end
  end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- Memory stage of the 5-stage CPU pipeline; consumes the execute-stage bundle (EX_out, MemWrite_data, DestReg, control bits).
- Registers the bundle, runs the data-memory request/ready handshake for loads and stores, and stalls upstream while an access is outstanding.
- Emits a one-cycle writeback bundle to the WB stage.

Parameters:
DATA_W, 32, data/address width
REG_W, 5, register-index width
MEM_TIMEOUT, 64, cycles in ACCESS before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX bundle valid this cycle
RegWrite_in  input  1  writeback enable
MemWrite_in  input  1  store
MemRead_in  input  1  load
MemToReg_in  input  1  1: wb data = memory read data; 0: wb data = EX_out
MemSrc_in  input  1  1: stack push addressing (addr = EX_out - 1); 0: addr = EX_out
DestReg_in  input  REG_W  destination register
EX_out_in  input  DATA_W  ALU result / address
MemWrite_data_in  input  DATA_W  store data
mem_stall  output  1  upstream must hold its bundle
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  DATA_W  word address
dmem_wdata  output  DATA_W  write data
dmem_ready  input  1  memory accepts/completes request this cycle
dmem_rdata  input  DATA_W  read data, valid when dmem_ready=1
wb_valid  output  1  writeback bundle valid (1-cycle pulse)
wb_RegWrite  output  1  register-file write enable
wb_DestReg  output  REG_W  register-file index
wb_data  output  DATA_W  register-file data
mem_err  output  1  access aborted (pulse)

Behaviour:
- Reset: state IDLE; all outputs 0; captured bundle cleared; any outstanding request is abandoned and dmem_req=0 from the cycle after the reset edge.
- States: IDLE, ACCESS.
- Accept: ex_valid=1 and state IDLE. The bundle is captured at that clock edge. ex_valid is ignored while mem_stall=1.
- Non-memory op (MemRead=MemWrite=0): stays in IDLE; wb_valid=1 the next cycle. Latency 1. Back-to-back accepts give consecutive wb_valid pulses.
- Memory op: goes to ACCESS on the edge after accept.
  - mem_stall = (state==ACCESS), combinational.
  - In ACCESS: dmem_req=1; dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ready=1 is sampled.
  - On the ready edge: rdata is captured, dmem_req drops, state returns to IDLE, and wb_valid=1 the following cycle.
  - Minimum latency: accept at t, req at t+1, ready at t+1, wb_valid at t+2.
- MemRead and MemWrite both 1: treated as a store; wb_data = EX_out regardless of MemToReg.
- Address: MemSrc=1 gives EX_out - 1, modulo 2^DATA_W, so 0 wraps to 0xFFFFFFFF. MemSrc=0 gives EX_out.
- wb_data = (MemToReg and MemRead and not MemWrite) ? captured rdata : EX_out. wb_RegWrite and wb_DestReg come from the captured bundle.
- wb_valid is a single-cycle pulse; other wb_* outputs hold their last value when wb_valid=0.
- dmem_ready while not in ACCESS is ignored.
- A new accept is possible in the same cycle as wb_valid (state already IDLE).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without ready. When the count reaches MEM_TIMEOUT:
  - dmem_req drops and state returns to IDLE;
  - next cycle wb_valid=1 with wb_RegWrite forced 0, and mem_err=1 for one cycle.
  - Ready arriving in the same cycle as the timeout: ready wins, no error.
- Undefined: the block waits indefinitely and mem_err is tied 0. The port is always present.

Decomposition:
- Shared package cpu_pkg: DATA_W, REG_W, SP_REG = 5'h1B, and the mem-stage state enum {IDLE, ACCESS}.
- One sub-module is natural: ex_mem_reg, the capture register for the EX bundle with load enable and synchronous clear.

Test Plan:
1. Non-memory op: RegWrite=1, DestReg=3, EX_out=0x0000_0042 -> next cycle wb_valid=1, wb_DestReg=3, wb_data=0x42, dmem_req never asserted.
2. Load, MemToReg=1, EX_out=0x100, ready after 3 wait cycles, rdata=0xDEADBEEF -> dmem_req high 4 cycles with addr 0x100 and we=0; mem_stall high for those cycles; wb_data=0xDEADBEEF one cycle after ready.
3. Call push: MemWrite=1, MemSrc=1, EX_out=0, data=0x2000 -> addr=0xFFFFFFFF, we=1, wdata=0x2000; wb_data=0x0.
4. New ex_valid held during a stall -> ignored until stall drops, then accepted exactly once.
5. rst asserted mid-ACCESS -> dmem_req=0 and wb_valid=0 next cycle; the following op completes normally.
6. MEM_TIMEOUT_EN with MEM_TIMEOUT=4 and ready never asserted -> req drops after 4 cycles; wb_valid=1, wb_RegWrite=0, mem_err=1 for one cycle.
